// File: rtl/a2d_scan_seq.sv
`default_nettype none
// ============================================================================
// Module   : a2d_scan_seq
// Brief    : Periodic channel-scan sequencer for the A2D SPI interface, with
//            per-channel result registers and a conversion watchdog.
//            Define A2D_AVG_EN to store a first-order IIR average instead of
//            the raw conversion result.
// Revision : 1.0  initial release
// ============================================================================
module a2d_scan_seq #(
    parameter int NUM_CH      = 8,
    parameter int SCAN_PERIOD = 1024,
    parameter int TIMEOUT     = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              err_clr,
    output logic              strt_cnv,
    output logic [2:0]        chnnl,
    input  logic              cnv_cmplt,
    input  logic [11:0]       res,
    input  logic [2:0]        rd_ch,
    output logic [11:0]       rd_data,
    output logic [NUM_CH-1:0] valid_mask,
    output logic              scan_done,
    output logic              err
);

    localparam int PW = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;
    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW-1:0] C_PERIOD_LOAD = PW'(SCAN_PERIOD - 1);
    localparam logic [WW-1:0] C_WDOG_LAST   = WW'(TIMEOUT - 1);
    localparam logic [2:0]    C_LAST_CH     = 3'(NUM_CH - 1);
    localparam logic [3:0]    C_NUM_CH      = 4'(NUM_CH);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        WAIT_CMPLT = 3'd2,
        STORE      = 3'd3,
        GAP        = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_ch_idx;
    logic [2:0]    w_ch_idx_nxt;
    logic [PW-1:0] r_period_cnt;
    logic [WW-1:0] r_wdog;
    logic [11:0]   r_res_cap;
    logic [11:0]   r_ch_data [8];
    logic [11:0]   w_store_val;
    logic          w_scan_start;
    logic          w_capture;
    logic          w_store;
    logic          w_timeout;
    logic          w_last_ch;

    assign w_last_ch = (r_ch_idx == C_LAST_CH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ch_idx_nxt = r_ch_idx;
        w_scan_start = 1'b0;
        w_capture    = 1'b0;
        w_store      = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_nxt  = START;
                    w_ch_idx_nxt = 3'd0;
                    w_scan_start = 1'b1;
                end
            end
            START: begin
                w_state_nxt = WAIT_CMPLT;
            end
            WAIT_CMPLT: begin
                if (cnv_cmplt) begin
                    w_capture   = 1'b1;
                    w_state_nxt = STORE;
                end else if (r_wdog == C_WDOG_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = GAP;
                end
            end
            STORE: begin
                w_store = 1'b1;
                if (w_last_ch) begin
                    w_state_nxt = GAP;
                end else if (en) begin
                    w_ch_idx_nxt = r_ch_idx + 3'd1;
                    w_state_nxt  = START;
                end else begin
                    // en dropped mid-scan: abandon the remaining channels
                    w_state_nxt = IDLE;
                end
            end
            GAP: begin
                if (r_period_cnt == '0) begin
                    if (en) begin
                        w_state_nxt  = START;
                        w_ch_idx_nxt = 3'd0;
                        w_scan_start = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch_idx     <= 3'd0;
            strt_cnv     <= 1'b0;
            chnnl        <= 3'd0;
            scan_done    <= 1'b0;
            err          <= 1'b0;
            r_period_cnt <= '0;
            r_wdog       <= '0;
            r_res_cap    <= '0;
            valid_mask   <= '0;
        end else begin
            r_ch_idx  <= w_ch_idx_nxt;
            strt_cnv  <= (w_state_nxt == START);
            scan_done <= w_store && w_last_ch;
            if (w_state_nxt == START) begin
                chnnl <= w_ch_idx_nxt;
            end
            // Period counter free-runs from every scan start and parks at zero
            if (w_scan_start) begin
                r_period_cnt <= C_PERIOD_LOAD;
            end else if (r_period_cnt != '0) begin
                r_period_cnt <= r_period_cnt - PW'(1);
            end
            if (r_state == START) begin
                r_wdog <= '0;
            end else if (r_state == WAIT_CMPLT) begin
                r_wdog <= r_wdog + WW'(1);
            end
            if (w_capture) begin
                r_res_cap <= res;
            end
            if (w_timeout) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_store && (r_ch_idx == 3'(i))) begin
                    valid_mask[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_ch_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_store && (r_ch_idx == 3'(i))) begin
                    r_ch_data[i] <= w_store_val;
                end
            end
        end
    end

`ifdef A2D_AVG_EN
    logic [11:0]        w_cur;
    logic               w_cur_valid;
    logic signed [12:0] w_diff;

    always_comb begin
        w_cur       = r_ch_data[r_ch_idx];
        w_cur_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_ch_idx == 3'(i)) begin
                w_cur_valid = valid_mask[i];
            end
        end
        w_diff      = $signed({1'b0, r_res_cap}) - $signed({1'b0, w_cur});
        // First sample of a channel seeds the filter directly
        w_store_val = w_cur_valid ? (w_cur + 12'(w_diff >>> 2)) : r_res_cap;
    end
`else
    assign w_store_val = r_res_cap;
`endif

    // Registers are only updated at the clock edge, so a same-cycle read sees the old value
    assign rd_data = ({1'b0, rd_ch} < C_NUM_CH) ? r_ch_data[rd_ch] : 12'h000;

endmodule
`default_nettype wire

// File: tb/tb_a2d_scan_seq.sv
`default_nettype none
// Self-checking bench for a2d_scan_seq: read-back table, randomized scans against a
// per-channel result model, watchdog, en-drop, reset and scan-overrun sequences.
module tb_a2d_scan_seq;

    localparam int NCH = 4;
`ifdef A2D_AVG_EN
    localparam bit          AVG_ON  = 1'b1;
    localparam logic [11:0] AVG_EXP = 12'h500;
`else
    localparam bit          AVG_ON  = 1'b0;
    localparam logic [11:0] AVG_EXP = 12'h800;
`endif

    logic           clk = 1'b0;
    logic           rst, en, err_clr, cnv_cmplt, strt_cnv, scan_done, err;
    logic [11:0]    res, rd_data;
    logic [2:0]     chnnl, rd_ch;
    logic [NCH-1:0] valid_mask;

    logic           ov_en, ov_cnv_cmplt, ov_strt, ov_done_p, ov_err;
    logic [11:0]    ov_res, ov_rd_data;
    logic [2:0]     ov_chnnl, ov_rd_ch;
    logic [NCH-1:0] ov_valid;

    a2d_scan_seq #(.NUM_CH(NCH), .SCAN_PERIOD(200), .TIMEOUT(50)) u_dut (
        .clk(clk), .rst(rst), .en(en), .err_clr(err_clr), .strt_cnv(strt_cnv),
        .chnnl(chnnl), .cnv_cmplt(cnv_cmplt), .res(res), .rd_ch(rd_ch),
        .rd_data(rd_data), .valid_mask(valid_mask), .scan_done(scan_done), .err(err)
    );

    a2d_scan_seq #(.NUM_CH(NCH), .SCAN_PERIOD(20), .TIMEOUT(50)) u_dut_ov (
        .clk(clk), .rst(rst), .en(ov_en), .err_clr(err_clr), .strt_cnv(ov_strt),
        .chnnl(ov_chnnl), .cnv_cmplt(ov_cnv_cmplt), .res(ov_res), .rd_ch(ov_rd_ch),
        .rd_data(ov_rd_data), .valid_mask(ov_valid), .scan_done(ov_done_p), .err(ov_err)
    );

    always #50 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int strt_ch[$];
    int strt_t[$];
    int done_cnt = 0;
    int ov_ch[$];
    int ov_t[$];
    int ov_done_cnt = 0;

    // Reference model: what each channel register should hold
    int exp_data [NCH];
    bit exp_valid[NCH];

    int skip_ch  = 7;
    int ch0_val  = -1;
    bit res_rand = 1'b0;
    bit lat_rand = 1'b0;

    typedef struct {
        logic [2:0]  sel;
        logic [11:0] data;
    } rd_vec_t;
    rd_vec_t rd_tab[8];

    function automatic int avg_calc(input int old_v, input int new_v);
        int d;
        d = new_v - old_v;
        return (old_v + ((d >= 0) ? d / 4 : -((3 - d) / 4))) & 32'hFFF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, expv);
        end
    endtask

    task automatic nstep(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_strt(input int ch, input int budget, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            if (strt_cnv && int'(chnnl) == ch) ok = 1'b1;
        end
        chk(nm, 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input int budget, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            if (scan_done) ok = 1'b1;
        end
        chk(nm, 32'(ok), 32'd1);
    endtask

    task automatic check_model(input string nm);
        logic [NCH-1:0] m;
        m = '0;
        for (int i = 0; i < NCH; i++) begin
            rd_ch = 3'(i);
            #1;
            chk({nm, "_rd"}, 32'(rd_data), 32'(exp_data[i]));
            m[i] = exp_valid[i];
        end
        chk({nm, "_valid"}, 32'(valid_mask), 32'(m));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nstep(2);
        rst = 1'b0;
        nstep(1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (strt_cnv) begin
            strt_ch.push_back(int'(chnnl));
            strt_t.push_back(cyc);
        end
        if (scan_done) done_cnt++;
        if (ov_strt) begin
            ov_ch.push_back(int'(ov_chnnl));
            ov_t.push_back(cyc);
        end
        if (ov_done_p) ov_done_cnt++;
    end

    // A2D interface model for the main DUT; keeps the expected register contents
    initial begin
        int          cnt, pch;
        bit          live;
        logic [11:0] v;
        cnt = 0; pch = 0; live = 1'b0;
        cnv_cmplt = 1'b0;
        res = '0;
        for (int i = 0; i < NCH; i++) begin
            exp_data[i]  = 0;
            exp_valid[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            cnv_cmplt = 1'b0;
            if (rst) begin
                live = 1'b0;
                for (int i = 0; i < NCH; i++) begin
                    exp_data[i]  = 0;
                    exp_valid[i] = 1'b0;
                end
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    if (pch == 0 && ch0_val >= 0) v = 12'(ch0_val);
                    else if (res_rand)            v = 12'($urandom);
                    else                          v = 12'h100 + 12'(pch);
                    cnv_cmplt = 1'b1;
                    res       = v;
                    if (live) begin
                        exp_data[pch]  = (AVG_ON && exp_valid[pch]) ? avg_calc(exp_data[pch], int'(v)) : int'(v);
                        exp_valid[pch] = 1'b1;
                    end
                end
            end
            if (strt_cnv && !rst && int'(chnnl) != skip_ch) begin
                pch  = int'(chnnl);
                cnt  = lat_rand ? int'($urandom_range(20, 1)) : 10;
                live = 1'b1;
            end
        end
    end

    initial begin
        int cnt, pch;
        cnt = 0; pch = 0;
        ov_cnv_cmplt = 1'b0;
        ov_res = '0;
        forever begin
            @(negedge clk);
            ov_cnv_cmplt = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    ov_cnv_cmplt = 1'b1;
                    ov_res = 12'h200 + 12'(pch);
                end
            end
            if (ov_strt) begin
                pch = int'(ov_chnnl);
                cnt = 10;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int mark, dc, ns, t_first;
        rst = 1'b1; en = 1'b0; err_clr = 1'b0; rd_ch = '0; ov_en = 1'b0; ov_rd_ch = '0;
        for (int i = 0; i < 8; i++) begin
            rd_tab[i].sel  = 3'(i);
            rd_tab[i].data = (i < NCH) ? 12'h100 + 12'(i) : 12'h000;
        end

        nstep(2);
        chk("rst_strt", 32'(strt_cnv), 0);
        chk("rst_chnnl", 32'(chnnl), 0);
        chk("rst_done", 32'(scan_done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_valid", 32'(valid_mask), 0);
        chk("rst_rd", 32'(rd_data), 0);
        rst = 1'b0;
        nstep(5);
        chk("idle_no_strt", 32'(strt_ch.size()), 0);

        // Fixed-value scan with read-back table
        mark = strt_ch.size();
        dc   = done_cnt;
        en   = 1'b1;
        wait_done(300, "scan1_done");
        nstep(2);
        chk("scan1_nstrt", 32'(strt_ch.size() - mark), 4);
        for (int i = 0; i < NCH; i++) chk("scan1_order", 32'(strt_ch[mark + i]), 32'(i));
        chk("scan1_done_cnt", 32'(done_cnt - dc), 1);
        chk("scan1_valid", 32'(valid_mask), 32'hF);
        for (int i = 0; i < 8; i++) begin
            rd_ch = rd_tab[i].sel;
            #1;
            chk("rd_tab", 32'(rd_data), 32'(rd_tab[i].data));
        end

        // Scan period and randomized results
        t_first  = strt_t[mark];
        res_rand = 1'b1;
        lat_rand = 1'b1;
        wait_strt(0, 300, "scan2_start");
        chk("scan_period", 32'(strt_t[strt_t.size() - 1] - t_first), 200);
        wait_done(200, "scan2_done");
        check_model("scan2");

        // en dropped while ch1 is converting
        wait_strt(1, 300, "endrop_ch1");
        ns = strt_ch.size();
        dc = done_cnt;
        en = 1'b0;
        nstep(40);
        chk("endrop_no_ch2", 32'(strt_ch.size()), 32'(ns));
        chk("endrop_no_done", 32'(done_cnt), 32'(dc));
        check_model("endrop");
        en = 1'b1;
        wait_strt(0, 3, "endrop_idle_restart");
        wait_done(200, "rescan_done");
        check_model("rescan");

        // Reset in the middle of a conversion
        lat_rand = 1'b0;
        wait_strt(1, 300, "rstmid_ch1");
        nstep(3);
        rst = 1'b1;
        en  = 1'b0;
        nstep(1);
        chk("rstmid_strt", 32'(strt_cnv), 0);
        chk("rstmid_chnnl", 32'(chnnl), 0);
        chk("rstmid_err", 32'(err), 0);
        chk("rstmid_valid", 32'(valid_mask), 0);
        nstep(1);
        rst = 1'b0;
        ns  = strt_ch.size();
        nstep(15);
        chk("rstmid_no_strt", 32'(strt_ch.size()), 32'(ns));
        check_model("rstmid");

        // Watchdog on ch2
        skip_ch = 2;
        dc      = done_cnt;
        en      = 1'b1;
        wait_strt(2, 200, "wdog_ch2");
        nstep(48);
        chk("wdog_err_early", 32'(err), 0);
        nstep(4);
        chk("wdog_err_set", 32'(err), 1);
        chk("wdog_no_done", 32'(done_cnt), 32'(dc));
        check_model("wdog");
        err_clr = 1'b1;
        nstep(1);
        err_clr = 1'b0;
        chk("err_clr", 32'(err), 0);
        skip_ch = 7;
        wait_done(300, "after_err_done");
        check_model("after_err");
        chk("after_err_err", 32'(err), 0);

        // Averaging / raw store on ch0
        en = 1'b0;
        do_reset();
        res_rand = 1'b0;
        ch0_val  = 12'h400;
        en       = 1'b1;
        wait_done(300, "avg1_done");
        rd_ch = 3'd0;
        #1;
        chk("avg_first", 32'(rd_data), 32'h400);
        ch0_val = 12'h800;
        wait_done(300, "avg2_done");
        rd_ch = 3'd0;
        #1;
        chk("avg_second", 32'(rd_data), 32'(AVG_EXP));
        check_model("avg");
        ch0_val = -1;
        en = 1'b0;

        // Overrunning scans on the short-period instance
        ov_en = 1'b1;
        for (int i = 0; i < 200 && ov_t.size() < 8; i++) nstep(1);
        chk("ov_8_strts", 32'(ov_t.size() >= 8), 1);
        for (int i = 0; i < 8; i++) chk("ov_order", 32'(ov_ch[i]), 32'(i % NCH));
        chk("ov_wrap_gap", 32'(ov_t[4] - ov_t[3]), 32'(ov_t[3] - ov_t[2] + 1));
        chk("ov_done_cnt", 32'(ov_done_cnt), 1);
        chk("ov_valid", 32'(ov_valid), 32'hF);
        chk("ov_err", 32'(ov_err), 0);
        for (int i = 0; i < NCH; i++) begin
            ov_rd_ch = 3'(i);
            #1;
            chk("ov_rd", 32'(ov_rd_data), 32'h200 + 32'(i));
        end
        ov_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
